fetch_ctrl: RTL and testbench

- Fetch-stage controller for the 16-bit core. Sits directly upstream of the instruction memory.
- Owns the PC and drives the memory address and enable. Consumes the memory's combinational read data and error flag.
- Registers each fetched instruction into the IF/ID boundary with a valid/ready handshake toward decode.
- Handles redirects from execute, halt detection and misaligned-fetch faults.

---
 rtl/fetch_ctrl.sv | 113 +++++++++++
 tb/tb_fetch_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC, drives instruction memory and
// registers fetched words into the IF/ID boundary with a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal fetch; redirects honoured
// HALTED  | HALT captured; no further fetch until rst
// FAULT   | misaligned fetch seen; no further fetch until rst
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000,
  parameter logic [15:0] NOP_INSTR   = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        id_ready,
  input  logic [15:0] imem_data,
  input  logic        imem_err,
  output logic [15:0] imem_addr,
  output logic        imem_enable,
  output logic        imem_wr,
  output logic        if_id_valid,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic [15:0] if_id_pc_plus2,
  output logic        halted,
  output logic        fault,
  output logic [15:0] fault_pc
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic        valid_nxt;
  logic [15:0] instr_nxt;
  logic [15:0] id_pc_nxt;
  logic [15:0] id_pc2_nxt;
  logic [15:0] fault_pc_nxt;
  logic        advance;

  assign advance     = ~if_id_valid | id_ready;
  assign imem_enable = (state == ST_RUN) & advance & ~redirect_valid & ~rst;
  assign imem_addr   = pc;
  assign imem_wr     = 1'b0;
  assign halted      = (state == ST_HALTED);
  assign fault       = (state == ST_FAULT);

  // Next-state and IF/ID update; redirect beats fault, fault beats capture.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    valid_nxt    = if_id_valid;
    instr_nxt    = if_id_instr;
    id_pc_nxt    = if_id_pc;
    id_pc2_nxt   = if_id_pc_plus2;
    fault_pc_nxt = fault_pc;
    if ((state == ST_RUN) && redirect_valid) begin
      // Flush: whatever IF/ID held belongs to the wrong path.
      pc_nxt    = redirect_pc;
      valid_nxt = 1'b0;
      instr_nxt = NOP_INSTR;
    end else if (imem_enable && imem_err) begin
      valid_nxt    = 1'b0;
      instr_nxt    = NOP_INSTR;
      state_nxt    = ST_FAULT;
      fault_pc_nxt = pc;
    end else if (imem_enable) begin
      valid_nxt  = 1'b1;
      instr_nxt  = imem_data;
      id_pc_nxt  = pc;
      id_pc2_nxt = pc + 16'd2;
      if (imem_data[15:11] == HALT_OPCODE) begin
        // PC stays on the HALT so a post-mortem sees where fetch stopped.
        state_nxt = ST_HALTED;
      end else begin
        pc_nxt = pc + 16'd2;
      end
    end else if (advance) begin
      // Decode took the held word (or nothing was held) and nothing new came in.
      valid_nxt = 1'b0;
      instr_nxt = NOP_INSTR;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_RUN;
      pc             <= RESET_PC;
      if_id_valid    <= 1'b0;
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= 16'h0000;
      if_id_pc_plus2 <= 16'h0000;
      fault_pc       <= 16'h0000;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      if_id_valid    <= valid_nxt;
      if_id_instr    <= instr_nxt;
      if_id_pc       <= id_pc_nxt;
      if_id_pc_plus2 <= id_pc2_nxt;
      fault_pc       <= fault_pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a vector table for the main run followed by
// hand-written halt, misaligned-fault and PC-wrap sequences.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        id_ready;
  logic [15:0] imem_data;
  logic        imem_err;
  logic [15:0] imem_addr;
  logic        imem_enable;
  logic        imem_wr;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_plus2;
  logic        halted;
  logic        fault;
  logic [15:0] fault_pc;

  int checks = 0;
  int errors = 0;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .imem_data      (imem_data),
    .imem_err       (imem_err),
    .imem_addr      (imem_addr),
    .imem_enable    (imem_enable),
    .imem_wr        (imem_wr),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .halted         (halted),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  always #5 clk = ~clk;

  // Memory image: three known words, a HALT at 6, everything else a non-HALT word.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'h1111;
      16'h0002: mem_word = 16'h2222;
      16'h0004: mem_word = 16'h3333;
      16'h0006: mem_word = 16'h0000;
      default:  mem_word = 16'h8000 | (a >> 1);
    endcase
  endfunction

  always_comb begin
    imem_data = mem_word(imem_addr);
    imem_err  = imem_enable & imem_addr[0];
  end

  typedef struct packed {
    logic        rst;
    logic        rv;
    logic [15:0] rpc;
    logic        rdy;
    logic        exp_en;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_instr;
    logic        chk_pc;
    logic [15:0] exp_pc;
    logic [15:0] exp_pc2;
    logic        exp_halted;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic r, input logic rv, input logic [15:0] rpc,
                              input logic rdy, input logic en, input logic [15:0] addr,
                              input logic vld, input logic [15:0] ins, input logic cpc,
                              input logic [15:0] ipc, input logic [15:0] ipc2,
                              input logic hlt);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.exp_en = en; v.exp_addr = addr;
    v.exp_valid = vld; v.exp_instr = ins;
    v.chk_pc = cpc; v.exp_pc = ipc; v.exp_pc2 = ipc2;
    v.exp_halted = hlt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [15:0] rp, input logic rd);
    @(negedge clk);
    rst = r;
    redirect_valid = rv;
    redirect_pc = rp;
    id_ready = rd;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    id_ready = 1'b1;

    //                rst rv  rpc       rdy  en addr      vld instr    cpc pc        pc2       hlt
    vecs[0]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hxxxx, 1'b0, 16'h0800, 1'b1, 16'h0000, 16'h0000, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h1111, 1'b1, 16'h0000, 16'h0002, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h2222, 1'b1, 16'h0002, 16'h0004, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h2222, 1'b1, 16'h0002, 16'h0004, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h2222, 1'b1, 16'h0002, 16'h0004, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h2222, 1'b1, 16'h0002, 16'h0004, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h3333, 1'b1, 16'h0004, 16'h0006, 1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0006, 1'b0, 16'h0800, 1'b0, 16'h0000, 16'h0000, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040, 1'b1, 16'h8020, 1'b1, 16'h0040, 16'h0042, 1'b0);
    vecs[9]  = mk(1'b0, 1'b1, 16'h0006, 1'b1, 1'b0, 16'h0042, 1'b0, 16'h0800, 1'b0, 16'h0000, 16'h0000, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0006, 1'b1, 16'h0000, 1'b1, 16'h0006, 16'h0008, 1'b1);
    vecs[11] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0006, 1'b1, 16'h0000, 1'b1, 16'h0006, 16'h0008, 1'b1);
    vecs[12] = mk(1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0006, 1'b0, 16'h0800, 1'b0, 16'h0000, 16'h0000, 1'b1);
    vecs[13] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0006, 1'b0, 16'h0800, 1'b0, 16'h0000, 16'h0000, 1'b1);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      chk($sformatf("v%0d_en", i), 16'(imem_enable), 16'(vecs[i].exp_en));
      if (i != 0) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      edge_wait();
      chk($sformatf("v%0d_valid", i), 16'(if_id_valid), 16'(vecs[i].exp_valid));
      chk($sformatf("v%0d_instr", i), if_id_instr, vecs[i].exp_instr);
      chk($sformatf("v%0d_halted", i), 16'(halted), 16'(vecs[i].exp_halted));
      chk($sformatf("v%0d_fault", i), 16'(fault), 16'h0000);
      if (vecs[i].chk_pc) begin
        chk($sformatf("v%0d_pc", i), if_id_pc, vecs[i].exp_pc);
        chk($sformatf("v%0d_pc2", i), if_id_pc_plus2, vecs[i].exp_pc2);
      end
    end
    chk("imem_wr", 16'(imem_wr), 16'h0000);

    // Halted: fetch stays off for 20 cycles, redirects ignored.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, i[0], 16'h0100, i[1]);
      chk($sformatf("halt_en_%0d", i), 16'(imem_enable), 16'h0000);
      chk($sformatf("halt_addr_%0d", i), imem_addr, 16'h0006);
      edge_wait();
    end
    chk("halt_still_halted", 16'(halted), 16'h0001);

    // Misaligned redirect: fault only on the following fetch.
    drive(1'b1, 1'b0, 16'h0000, 1'b1);
    edge_wait();
    chk("mis_rst_halted", 16'(halted), 16'h0000);
    drive(1'b0, 1'b1, 16'h0013, 1'b1);
    chk("mis_redir_en", 16'(imem_enable), 16'h0000);
    edge_wait();
    chk("mis_redir_fault", 16'(fault), 16'h0000);
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("mis_fetch_err", 16'(imem_err), 16'h0001);
    chk("mis_fetch_addr", imem_addr, 16'h0013);
    edge_wait();
    chk("mis_fault", 16'(fault), 16'h0001);
    chk("mis_fault_pc", fault_pc, 16'h0013);
    chk("mis_valid", 16'(if_id_valid), 16'h0000);
    chk("mis_instr", if_id_instr, 16'h0800);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 16'h0000, 1'b1);
      chk($sformatf("mis_en_%0d", i), 16'(imem_enable), 16'h0000);
      edge_wait();
    end
    chk("mis_fault_hold", 16'(fault), 16'h0001);
    drive(1'b1, 1'b0, 16'h0000, 1'b1);
    edge_wait();
    chk("mis_rst_fault", 16'(fault), 16'h0000);
    chk("mis_rst_fault_pc", fault_pc, 16'h0000);
    chk("mis_rst_pc", imem_addr, 16'h0000);

    // PC wrap at the top of the address space.
    drive(1'b0, 1'b1, 16'hFFFE, 1'b1);
    edge_wait();
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("wrap_addr0", imem_addr, 16'hFFFE);
    edge_wait();
    chk("wrap_pc0", if_id_pc, 16'hFFFE);
    chk("wrap_pc2_0", if_id_pc_plus2, 16'h0000);
    chk("wrap_instr0", if_id_instr, 16'hFFFF);
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("wrap_addr1", imem_addr, 16'h0000);
    edge_wait();
    chk("wrap_pc1", if_id_pc, 16'h0000);
    chk("wrap_pc2_1", if_id_pc_plus2, 16'h0002);
    chk("wrap_instr1", if_id_instr, 16'h1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
